result_window_stats: RTL and testbench

- Downstream consumer of the registered 9-bit signed selector/ALU result (a, b, a+b, a-b).
- Collects the result stream into fixed windows of 2^LOG2_WIN accepted samples.
- Per window, produces signed sum, floor average, minimum and maximum.
- Outputs are held behind a valid/ready handshake; backpressure stalls input acceptance.

---
 rtl/result_window_stats.sv | 139 +++++++++++++
 tb/tb_result_window_stats.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_window_stats.sv
// Windowed statistics over a signed sample stream: per 2^LOG2_WIN accepted
// samples, emits the exact sum, floor average, minimum and maximum behind a valid/ready handshake.
module result_window_stats #(
    parameter int DW       = 9,
    parameter int LOG2_WIN = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DW-1:0]            in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [DW+LOG2_WIN-1:0]   out_sum,
    output logic signed [DW-1:0]            out_avg,
    output logic signed [DW-1:0]            out_min,
    output logic signed [DW-1:0]            out_max
);

    localparam int SW = DW + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] CNT_ZERO = {LOG2_WIN{1'b0}};
    localparam logic [LOG2_WIN-1:0] CNT_LAST = {LOG2_WIN{1'b1}};

    logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
    logic signed [SW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]  min_q, min_d;
    logic signed [DW-1:0]  max_q, max_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [DW-1:0]  avg_q, avg_d;
    logic signed [DW-1:0]  omin_q, omin_d;
    logic signed [DW-1:0]  omax_q, omax_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  first_s;
    logic                  last_s;
    logic signed [SW-1:0]  din_ext_s;
    logic signed [SW-1:0]  sum_s;
    logic signed [DW-1:0]  avg_s;
    logic signed [DW-1:0]  min_s;
    logic signed [DW-1:0]  max_s;

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_sum    = sum_q;
    assign out_avg    = avg_q;
    assign out_min    = omin_q;
    assign out_max    = omax_q;

    // Datapath: running sum/extrema including the current sample; the first
    // sample of a window restarts them, and first/last are independent so WIN=2 works.
    always_comb begin
        in_ready_s = !out_valid_q || out_ready;
        accept_s   = in_valid && in_ready_s;
        first_s    = (cnt_q == CNT_ZERO);
        last_s     = (cnt_q == CNT_LAST);
        din_ext_s  = {{LOG2_WIN{in_data[DW-1]}}, in_data};
        sum_s      = (first_s ? {SW{1'b0}} : acc_q) + din_ext_s;
        // Dropping the low LOG2_WIN bits of a two's complement value is floor division.
        avg_s      = sum_s[SW-1:LOG2_WIN];
        if (first_s || (in_data < min_q)) begin
            min_s = in_data;
        end else begin
            min_s = min_q;
        end
        if (first_s || (in_data > max_q)) begin
            max_s = in_data;
        end else begin
            max_s = max_q;
        end
    end

    // Next-state: accumulation, clear flush, window completion and output handshake.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        min_d       = min_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        avg_d       = avg_q;
        omin_d      = omin_q;
        omax_d      = omax_q;
        if (clear) begin
            cnt_d = CNT_ZERO;
            acc_d = {SW{1'b0}};
        end else if (accept_s) begin
            acc_d = sum_s;
            min_d = min_s;
            max_d = max_s;
            if (last_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + {{(LOG2_WIN-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (!clear && accept_s && last_s) begin
            out_valid_d = 1'b1;
            sum_d       = sum_s;
            avg_d       = avg_s;
            omin_d      = min_s;
            omax_d      = max_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= CNT_ZERO;
            acc_q       <= {SW{1'b0}};
            min_q       <= {DW{1'b0}};
            max_q       <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            sum_q       <= {SW{1'b0}};
            avg_q       <= {DW{1'b0}};
            omin_q      <= {DW{1'b0}};
            omax_q      <= {DW{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            omin_q      <= omin_d;
            omax_q      <= omax_d;
        end
    end

endmodule

// File: tb/tb_result_window_stats.sv
// Bench for result_window_stats: table vectors and corner sequences feed a
// scoreboard queue that is checked at every output handshake.
module tb_result_window_stats;

    typedef struct {
        int sum;
        int avg;
        int mn;
        int mx;
    } res_t;

    typedef struct {
        int   d0;
        int   d1;
        int   d2;
        int   d3;
        res_t r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [8:0]  in_data = 9'sd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [10:0] out_sum;
    logic signed [8:0]  out_avg, out_min, out_max;

    logic               in_valid2 = 1'b0;
    logic               in_ready2;
    logic signed [8:0]  in_data2 = 9'sd0;
    logic               out_valid2;
    logic               out_ready2 = 1'b1;
    logic signed [9:0]  out_sum2;
    logic signed [8:0]  out_avg2, out_min2, out_max2;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   win2_cnt = 0;
    int   win2_last = -1;
    res_t exp_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    result_window_stats #(.DW(9), .LOG2_WIN(2)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_avg(out_avg), .out_min(out_min), .out_max(out_max)
    );

    result_window_stats #(.DW(9), .LOG2_WIN(1)) u_dut2 (
        .clk(clk), .rst(rst), .clear(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_avg(out_avg2), .out_min(out_min2), .out_max(out_max2)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input int a, input int mn, input int mx);
        res_t r;
        r.sum = s; r.avg = a; r.mn = mn; r.mx = mx;
        exp_q.push_back(r);
    endtask

    // Drive one sample and hold it until accepted (bounded wait).
    task automatic send(input int v);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'(v);
        #1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for sample %0d", v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard for the WIN=4 instance: one pop per completed output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_out: got sum %0d expected no output", out_sum);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("out_sum", int'(out_sum), r.sum);
                chk("out_avg", int'(out_avg), r.avg);
                chk("out_min", int'(out_min), r.mn);
                chk("out_max", int'(out_max), r.mx);
            end
        end
    end

    // Checker for the WIN=2 instance: pairs (7,-8) every two cycles.
    always @(negedge clk) begin
        if (out_valid2 && out_ready2) begin
            chk("w2_sum", int'(out_sum2), -1);
            chk("w2_avg", int'(out_avg2), -1);
            chk("w2_min", int'(out_min2), -8);
            chk("w2_max", int'(out_max2), 7);
            if (win2_last >= 0) chk("w2_period", cyc - win2_last, 2);
            win2_last = cyc;
            win2_cnt++;
        end
    end

    initial begin
        vecs[0] = '{d0: 3,    d1: 1,    d2: 4,    d3: -2,   r: '{sum: 6,     avg: 1,    mn: -2,   mx: 4}};
        vecs[1] = '{d0: -1,   d1: -2,   d2: -1,   d3: -1,   r: '{sum: -5,    avg: -2,   mn: -2,   mx: -1}};
        vecs[2] = '{d0: 255,  d1: 255,  d2: 255,  d3: 255,  r: '{sum: 1020,  avg: 255,  mn: 255,  mx: 255}};
        vecs[3] = '{d0: -256, d1: -256, d2: -256, d3: -256, r: '{sum: -1024, avg: -256, mn: -256, mx: -256}};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_min", int'(out_min), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            push(vecs[i].r.sum, vecs[i].r.avg, vecs[i].r.mn, vecs[i].r.mx);
            send(vecs[i].d0);
            send(vecs[i].d1);
            send(vecs[i].d2);
            send(vecs[i].d3);
            chk("latency_valid", int'(out_valid), 1);
        end
        repeat (4) @(negedge clk);
        chk("table_drained", exp_q.size(), 0);

        // Backpressure: second window waits upstream until the consumer is ready.
        out_ready = 1'b0;
        push(10, 2, 1, 4);
        push(2, 0, -7, 8);
        fork
            begin
                send(1); send(2); send(3); send(4);
                send(-5); send(6); send(-7); send(8);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_valid_rise", int'(out_valid), 1);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", int'(in_ready), 0);
                    chk("bp_hold_sum", int'(out_sum), 10);
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);

        // Clear together with a valid sample discards the whole partial window.
        send(10);
        send(20);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 9'sd30;
        clear    = 1'b1;
        #1;
        chk("clear_in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        push(10, 2, 1, 4);
        send(1); send(2); send(3); send(4);
        repeat (4) @(negedge clk);
        chk("clear_drained", exp_q.size(), 0);

        // Reset mid-window discards the two partial samples and zeroes outputs.
        send(7);
        send(9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_sum", int'(out_sum), 0);
        chk("mrst_out_avg", int'(out_avg), 0);
        chk("mrst_out_max", int'(out_max), 0);
        push(20, 5, 5, 5);
        send(5); send(5); send(5);
        @(negedge clk);
        chk("mrst_no_early", int'(out_valid), 0);
        send(5);
        repeat (4) @(negedge clk);
        chk("mrst_drained", exp_q.size(), 0);

        // WIN=2 instance, continuous stream.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_data2  = (i % 2 == 0) ? 9'sd7 : -9'sd8;
            #1;
            chk("w2_in_ready", int'(in_ready2), 1);
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("w2_windows", win2_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
